// File: rtl/sdm_pkg.sv
// Shared definitions for the sdm_mixer slice.
// - mix FSM state encoding
// - bit positions of the per-channel config word {ma_en, pan_r, pan_l, gain[2:0]}
// - accumulator width helper (wide enough that NCH terms of (2**IW-1) << 7 never overflow)
package sdm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_ACCUM   = 3'd2,
    ST_SAT     = 3'd3,
    ST_OUT     = 3'd4
  } sdm_state_t;

  localparam int CFG_W        = 6;
  localparam int CFG_GAIN_LSB = 0;
  localparam int CFG_GAIN_W   = 3;
  localparam int CFG_PAN_L    = 3;
  localparam int CFG_PAN_R    = 4;
  localparam int CFG_MA_EN    = 5;

  // Reset entry: gain 0, both pans on, averaging off.
  localparam logic [CFG_W-1:0] CFG_RESET = 6'b011000;

  function automatic int acc_width(input int iw, input int nch);
    return iw + 7 + $clog2(nch);
  endfunction

endpackage

// File: rtl/sdm_dsmod.sv
// First-order delta-sigma modulator for one output side.
// Ports:
//   clk24  - clock
//   reset  - synchronous active-high reset
//   ce     - update strobe (one clk24 cycle)
//   din    - W-bit input level (top bits of the PCM sample)
//   pwm    - 1-bit bitstream, the carry out of the last update
module sdm_dsmod #(
  parameter int W = 10
) (
  input  logic         clk24,
  input  logic         reset,
  input  logic         ce,
  input  logic [W-1:0] din,
  output logic         pwm
);

  logic [W:0] acc;

  // The previous carry is dropped before each add, so acc[W] is a pure
  // carry pulse and its duty equals din / 2**W.
  always_ff @(posedge clk24) begin
    if (reset) begin
      acc <= '0;
    end else if (ce) begin
      acc <= {1'b0, acc[W-1:0]} + {1'b0, din};
    end
  end

  assign pwm = acc[W];

endmodule

// File: rtl/sdm_mixer.sv
// Multi-channel mixer: once per frame snapshots all channel samples and the
// config table, sums gain-shifted (optionally moving-averaged) channel terms
// into left/right accumulators, saturates to OW bits and feeds a delta-sigma
// modulator per side.
//
// state   | meaning
// IDLE    | waiting for frame_ce
// CAPTURE | snapshot ch_data + config, push history, clear accumulators
// ACCUM   | add channel ch_idx term, NCH cycles
// SAT     | saturate accumulators, register pcm/clip on exit
// OUT     | pcm_l/pcm_r hold the new frame, pcm_valid high
//
// Ports:
//   clk24, reset      - clock, synchronous active-high reset
//   ch_data           - NCH packed IW-bit samples, channel i at [i*IW +: IW]
//   cfg_we/addr/data  - config write {ma_en, pan_r, pan_l, gain[2:0]}
//   clip_clr          - clears sticky clip flags
//   pcm_l, pcm_r      - mixed frame, pcm_valid pulses when they update
//   clip              - sticky {R, L} saturation flags
//   busy              - FSM outside IDLE
//   o_pwm             - delta-sigma bitstreams {R, L}
module sdm_mixer
  import sdm_pkg::*;
#(
  parameter int NCH        = 8,
  parameter int IW         = 8,
  parameter int OW         = 16,
  parameter int PWM_WIDTH  = 10,
  parameter int SAMPLE_DIV = 512,
  parameter int DS_DIV     = 8,
  parameter int MA_LOG2    = 2
) (
  input  logic                     clk24,
  input  logic                     reset,
  input  logic [NCH*IW-1:0]        ch_data,
  input  logic                     cfg_we,
  input  logic [$clog2(NCH)-1:0]   cfg_addr,
  input  logic [5:0]               cfg_data,
  input  logic                     clip_clr,
  output logic [OW-1:0]            pcm_l,
  output logic [OW-1:0]            pcm_r,
  output logic                     pcm_valid,
  output logic [1:0]               clip,
  output logic                     busy,
  output logic [1:0]               o_pwm
);

  localparam int AW    = $clog2(NCH);
  localparam int ACC_W = acc_width(IW, NCH);
  localparam int MA    = 1 << MA_LOG2;
  localparam int HW    = IW + MA_LOG2;
  localparam int FW    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int DW    = (DS_DIV > 1) ? $clog2(DS_DIV) : 1;
  localparam logic [AW-1:0] LAST_CH = AW'(NCH - 1);

  // Frame and delta-sigma dividers
  logic [FW-1:0] frame_cnt;
  logic          frame_ce;
  logic [DW-1:0] ds_cnt;
  logic          ds_ce;

  assign frame_ce = (frame_cnt == FW'(SAMPLE_DIV - 1));
  assign ds_ce    = (ds_cnt == DW'(DS_DIV - 1));

  always_ff @(posedge clk24) begin
    if (reset) begin
      frame_cnt <= '0;
      ds_cnt    <= '0;
    end else begin
      frame_cnt <= frame_ce ? '0 : frame_cnt + 1'b1;
      ds_cnt    <= ds_ce ? '0 : ds_cnt + 1'b1;
    end
  end

  // FSM
  sdm_state_t    state, state_nxt;
  logic [AW-1:0] ch_idx;

  always_ff @(posedge clk24) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE:    if (frame_ce) state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_ACCUM;
      ST_ACCUM:   if (ch_idx == LAST_CH) state_nxt = ST_SAT;
      ST_SAT:     state_nxt = ST_OUT;
      ST_OUT:     state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Live config table
  logic [CFG_W-1:0] cfg_tab [NCH];

  always_ff @(posedge clk24) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) cfg_tab[i] <= CFG_RESET;
    end else if (cfg_we && (int'(cfg_addr) < NCH)) begin
      cfg_tab[cfg_addr] <= cfg_data;
    end
  end

  // Snapshots. hist[i][0] is the newest entry and doubles as the frame's
  // sample snapshot, so no separate sample register is kept.
  logic [CFG_W-1:0] snap_cfg [NCH];
  logic [IW-1:0]    hist     [NCH][MA];

  always_ff @(posedge clk24) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        snap_cfg[i] <= CFG_RESET;
        for (int k = 0; k < MA; k++) hist[i][k] <= '0;
      end
    end else if (state == ST_CAPTURE) begin
      for (int i = 0; i < NCH; i++) begin
        snap_cfg[i] <= cfg_tab[i];
        hist[i][0]  <= ch_data[i*IW +: IW];
        for (int k = MA - 1; k > 0; k--) hist[i][k] <= hist[i][k-1];
      end
    end
  end

  // Term for the channel being accumulated
  logic [CFG_W-1:0] cur_cfg;
  logic [HW-1:0]    hsum;
  logic [IW-1:0]    cur_s;
  logic [ACC_W-1:0] term;

  always_comb begin
    cur_cfg = snap_cfg[ch_idx];
    hsum    = '0;
    for (int k = 0; k < MA; k++) hsum = hsum + HW'(hist[ch_idx][k]);
    cur_s   = cur_cfg[CFG_MA_EN] ? IW'(hsum >> MA_LOG2) : hist[ch_idx][0];
    term    = ACC_W'(cur_s) << cur_cfg[CFG_GAIN_LSB +: CFG_GAIN_W];
  end

  // Accumulators
  logic [ACC_W-1:0] acc_l, acc_r;

  always_ff @(posedge clk24) begin
    if (reset) begin
      acc_l  <= '0;
      acc_r  <= '0;
      ch_idx <= '0;
    end else begin
      case (state)
        ST_CAPTURE: begin
          acc_l  <= '0;
          acc_r  <= '0;
          ch_idx <= '0;
        end
        ST_ACCUM: begin
          if (cur_cfg[CFG_PAN_L]) acc_l <= acc_l + term;
          if (cur_cfg[CFG_PAN_R]) acc_r <= acc_r + term;
          ch_idx <= ch_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Saturation. Zero-extending by OW bits keeps the overflow test valid
  // even if the accumulator were narrower than the output.
  logic [ACC_W+OW-1:0] ext_l, ext_r;
  logic                over_l, over_r;
  logic [OW-1:0]       sat_l, sat_r;

  assign ext_l  = {{OW{1'b0}}, acc_l};
  assign ext_r  = {{OW{1'b0}}, acc_r};
  assign over_l = |ext_l[ACC_W+OW-1:OW];
  assign over_r = |ext_r[ACC_W+OW-1:OW];
  assign sat_l  = over_l ? {OW{1'b1}} : ext_l[OW-1:0];
  assign sat_r  = over_r ? {OW{1'b1}} : ext_r[OW-1:0];

  // Outputs are loaded on the SAT->OUT edge so the new samples and
  // pcm_valid are visible together for the whole OUT cycle.
  always_ff @(posedge clk24) begin
    if (reset) begin
      pcm_l     <= '0;
      pcm_r     <= '0;
      pcm_valid <= 1'b0;
      clip      <= 2'b00;
    end else begin
      pcm_valid <= (state == ST_SAT);
      if (state == ST_SAT) begin
        pcm_l <= sat_l;
        pcm_r <= sat_r;
      end
      // Set wins over a simultaneous clear.
      clip <= (clip & ~{2{clip_clr}}) | ({over_r, over_l} & {2{state == ST_SAT}});
    end
  end

  // Delta-sigma modulators
  sdm_dsmod #(.W(PWM_WIDTH)) u_dsmod_l (
    .clk24 (clk24),
    .reset (reset),
    .ce    (ds_ce),
    .din   (pcm_l[OW-1 -: PWM_WIDTH]),
    .pwm   (o_pwm[0])
  );

  sdm_dsmod #(.W(PWM_WIDTH)) u_dsmod_r (
    .clk24 (clk24),
    .reset (reset),
    .ce    (ds_ce),
    .din   (pcm_r[OW-1 -: PWM_WIDTH]),
    .pwm   (o_pwm[1])
  );

endmodule

// File: tb/tb_sdm_mixer.sv
module tb_sdm_mixer;

  localparam int NCH = 8;
  localparam int IW  = 8;
  localparam int OW  = 16;
  localparam int PW  = 10;
  localparam int SD  = 32;
  localparam int DS  = 4;
  localparam int MAL = 2;
  localparam int MA  = 4;
  localparam int AW  = 3;

  logic              clk24 = 1'b0;
  logic              reset = 1'b1;
  logic [NCH*IW-1:0] ch_data = '0;
  logic              cfg_we = 1'b0;
  logic [AW-1:0]     cfg_addr = '0;
  logic [5:0]        cfg_data = '0;
  logic              clip_clr = 1'b0;
  logic [OW-1:0]     pcm_l, pcm_r;
  logic              pcm_valid;
  logic [1:0]        clip;
  logic              busy;
  logic [1:0]        o_pwm;

  always #5 clk24 = ~clk24;

  sdm_mixer #(
    .NCH(NCH), .IW(IW), .OW(OW), .PWM_WIDTH(PW),
    .SAMPLE_DIV(SD), .DS_DIV(DS), .MA_LOG2(MAL)
  ) dut (
    .clk24     (clk24),
    .reset     (reset),
    .ch_data   (ch_data),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .clip_clr  (clip_clr),
    .pcm_l     (pcm_l),
    .pcm_r     (pcm_r),
    .pcm_valid (pcm_valid),
    .clip      (clip),
    .busy      (busy),
    .o_pwm     (o_pwm)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: cycle index since reset, frame arithmetic, plain sums.
  int     n = 0;
  bit     started = 1'b0;
  int     m_cfg  [NCH];
  int     m_hist [NCH][MA];
  int     exp_l, exp_r, exp_valid, exp_clip;
  int     pwm_acc [2];
  int     pending, pend_at, pend_l, pend_r, pend_clip, set_bits;
  longint sl, sr, term, s;

  always @(posedge clk24) begin
    if (reset) begin
      n = 0;
      started = 1'b1;
      for (int i = 0; i < NCH; i++) begin
        m_cfg[i] = 6'b011000;
        for (int k = 0; k < MA; k++) m_hist[i][k] = 0;
      end
      exp_l = 0; exp_r = 0; exp_valid = 0; exp_clip = 0;
      pwm_acc[0] = 0; pwm_acc[1] = 0;
      pending = 0;
    end else begin
      if (n % DS == DS - 1) begin
        pwm_acc[0] = pwm_acc[0] % (1 << PW) + (exp_l >> (OW - PW));
        pwm_acc[1] = pwm_acc[1] % (1 << PW) + (exp_r >> (OW - PW));
      end
      if (n >= SD && n % SD == 0) begin
        sl = 0; sr = 0;
        for (int i = 0; i < NCH; i++) begin
          for (int k = MA - 1; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
          m_hist[i][0] = int'(ch_data[i*IW +: IW]);
          if ((m_cfg[i] >> 5) & 1) begin
            s = 0;
            for (int k = 0; k < MA; k++) s += m_hist[i][k];
            s = s / MA;
          end else begin
            s = m_hist[i][0];
          end
          term = s * (longint'(1) << (m_cfg[i] & 7));
          if ((m_cfg[i] >> 3) & 1) sl += term;
          if ((m_cfg[i] >> 4) & 1) sr += term;
        end
        pend_clip = ((sr >= (1 << OW)) ? 2 : 0) | ((sl >= (1 << OW)) ? 1 : 0);
        pend_l = (sl >= (1 << OW)) ? (1 << OW) - 1 : int'(sl);
        pend_r = (sr >= (1 << OW)) ? (1 << OW) - 1 : int'(sr);
        pending = 1;
        pend_at = n + NCH + 2;
      end
      if (cfg_we) m_cfg[cfg_addr] = int'(cfg_data);
      n++;
      exp_valid = 0;
      set_bits = 0;
      if (pending && n == pend_at) begin
        exp_l = pend_l; exp_r = pend_r; exp_valid = 1;
        set_bits = pend_clip;
        pending = 0;
      end
      exp_clip = (clip_clr ? 0 : exp_clip) | set_bits;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk24) begin
    if (started) begin
      chk("pcm_l", pcm_l, exp_l);
      chk("pcm_r", pcm_r, exp_r);
      chk("pcm_valid", pcm_valid, exp_valid);
      chk("clip", clip, exp_clip);
      chk("busy", busy, (n >= SD && (n % SD) <= NCH + 2) ? 1 : 0);
      chk("o_pwm_l", o_pwm[0], (pwm_acc[0] >> PW) & 1);
      chk("o_pwm_r", o_pwm[1], (pwm_acc[1] >> PW) & 1);
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge clk24);
  endtask

  task automatic cfg_wr(input int a, input int d);
    @(negedge clk24);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_data = 6'(d);
    @(negedge clk24);
    cfg_we = 1'b0;
  endtask

  task automatic set_ch(input int i, input int v);
    ch_data[i*IW +: IW] = IW'(v);
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    @(negedge clk24);
    while (!pcm_valid && k < 3 * SD) begin
      @(negedge clk24);
      k++;
    end
    chk({tag, "_valid_seen"}, pcm_valid, 1);
  endtask

  task automatic wait_busy_rise(input string tag);
    int k;
    logic prev;
    k = 0;
    prev = busy;
    @(negedge clk24);
    while (!(busy && !prev) && k < 3 * SD) begin
      prev = busy;
      @(negedge clk24);
      k++;
    end
    chk({tag, "_busy_rise"}, busy && !prev, 1);
  endtask

  int k, ones;
  logic prev_pwm;

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;

    // Single channel, gain 5, left only
    ch_data = {$urandom, $urandom};
    set_ch(0, 8'h80);
    cfg_wr(0, 6'b001101);
    for (int i = 1; i < NCH; i++) cfg_wr(i, 0);
    wait_busy_rise("r037");
    k = 0;
    while (!pcm_valid && k < 40) begin
      cyc(1);
      k++;
    end
    chk("r037_capture_to_valid", k, NCH + 2);
    chk("r037_pcm_l", pcm_l, 16'h1000);
    chk("r037_pcm_r", pcm_r, 16'h0000);

    // Full overload on both sides
    for (int i = 0; i < NCH; i++) set_ch(i, 8'hFF);
    for (int i = 0; i < NCH; i++) cfg_wr(i, 6'b011111);
    wait_valid("r038a");
    wait_valid("r038b");
    chk("r038_pcm_l", pcm_l, 16'hFFFF);
    chk("r038_pcm_r", pcm_r, 16'hFFFF);
    chk("r038_clip", clip, 2'b11);
    cyc(2);
    clip_clr = 1'b1;
    cyc(1);
    clip_clr = 1'b0;
    chk("r038_clip_cleared", clip, 2'b00);
    wait_valid("r038c");
    chk("r038_clip_reset", clip, 2'b11);
    for (int i = 0; i < NCH; i++) set_ch(i, 8'h01);
    cyc(2);
    clip_clr = 1'b1;
    cyc(1);
    clip_clr = 1'b0;
    wait_valid("r038d");
    chk("r038_no_overload_pcm", pcm_l, 16'h0400);
    chk("r038_no_overload_clip", clip, 2'b00);

    // Moving average step on ch1
    ch_data = '0;
    for (int i = 0; i < NCH; i++) cfg_wr(i, (i == 1) ? 6'b101000 : 0);
    repeat (6) wait_valid("r039_flush");
    set_ch(1, 8'hFF);
    wait_valid("r039_1"); chk("r039_f1", pcm_l, 16'h003F);
    wait_valid("r039_2"); chk("r039_f2", pcm_l, 16'h007F);
    wait_valid("r039_3"); chk("r039_f3", pcm_l, 16'h00BF);
    wait_valid("r039_4"); chk("r039_f4", pcm_l, 16'h00FF);

    // Half-scale delta-sigma
    ch_data = '0;
    set_ch(0, 8'h80);
    set_ch(1, 8'h80);
    cfg_wr(0, 6'b001111);
    cfg_wr(1, 6'b001111);
    wait_valid("r040a");
    wait_valid("r040b");
    chk("r040_pcm_l", pcm_l, 16'h8000);
    cyc(DS);
    prev_pwm = o_pwm[0];
    ones = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(DS);
      chk("r040_alternate", o_pwm[0], !prev_pwm);
      chk("r040_zero_side", o_pwm[1], 0);
      prev_pwm = o_pwm[0];
      ones += int'(o_pwm[0]);
    end
    chk("r040_duty_ones", ones, 8);

    // Config write coincident with CAPTURE
    cfg_wr(0, 6'b001001);
    cfg_wr(1, 0);
    ch_data = '0;
    set_ch(0, 8'h10);
    wait_valid("r041a");
    wait_valid("r041b");
    chk("r041_base", pcm_l, 16'h0020);
    wait_busy_rise("r041");
    cfg_we = 1'b1; cfg_addr = 0; cfg_data = 6'b001011;
    cyc(1);
    cfg_we = 1'b0;
    wait_valid("r041c");
    chk("r041_old_gain", pcm_l, 16'h0020);
    wait_valid("r041d");
    chk("r041_new_gain", pcm_l, 16'h0080);

    // Reset during ACCUM
    wait_busy_rise("r042");
    cyc(3);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("r042_busy", busy, 0);
    chk("r042_pcm_l", pcm_l, 0);
    chk("r042_pcm_r", pcm_r, 0);
    k = 0;
    while (!pcm_valid && k < 200) begin
      cyc(1);
      k++;
    end
    chk("r042_first_valid_cycle", k, SD + NCH + 2);

    // Randomized frames
    for (int f = 0; f < 20; f++) begin
      ch_data = {$urandom, $urandom};
      repeat ($urandom_range(0, 3)) begin
        cyc($urandom_range(0, 8));
        cfg_wr($urandom_range(0, NCH - 1), $urandom_range(0, 63));
      end
      if ($urandom_range(0, 2) == 0) begin
        clip_clr = 1'b1;
        cyc($urandom_range(1, 20));
        clip_clr = 1'b0;
      end
      wait_valid("rand");
    end

    cyc(5);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
